// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access size codes, data width.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } lsu_state_e;

  // Illegal size code or an address not naturally aligned to the access size.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    unique case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: extracts and extends load data, and merges sub-word store
// data into a memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = word_i[{addr_lo_i, 3'b000} +: 8];
    half_v      = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    load_data_o = word_i;
    merged_o    = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
        merged_o    = word_i;
        merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o = {{16{sign_ext_i & half_v[15]}}, half_v};
        merged_o    = word_i;
        merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the pipeline and a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32  // only 32 is supported
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [1:0]        Req_Size,
  input  logic              Req_Signed,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_WData,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_RData,
  output logic              Rsp_Misalign,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  output logic              Mem_MemWrite,
  output logic              Mem_MemRead,
  input  logic [DATA_W-1:0] Mem_ReadData
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q, write_q, err_q;
  logic [DATA_W-1:0] wdata_q, word_q;
  logic              accept, req_err;
  logic [DATA_W-1:0] load_data, merged;

  assign accept  = Req_Valid & Req_Ready;
  assign req_err = is_misaligned(Req_Size, Req_Addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                state_d = StResp;
          else if (!Req_Write)        state_d = StLoad;
          else if (Req_Size == SZ_WORD) state_d = StStore;
          else                        state_d = StRmwRd;
        end
      end
      StLoad:  state_d = StResp;
      StStore: state_d = StResp;
      StRmwRd: state_d = StRmwWr;
      StRmwWr: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= Req_Addr;
        size_q   <= Req_Size;
        signed_q <= Req_Signed;
        write_q  <= Req_Write;
        err_q    <= req_err;
        wdata_q  <= Req_WData;
      end
      if (Mem_MemRead) word_q <= Mem_ReadData;
    end
  end

  lsu_align u_align (
    .word_i      (word_q),
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .sign_ext_i  (signed_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Ready is held low while reset is asserted so nothing is accepted during reset.
  assign Req_Ready     = Rst_n && (state_q == StIdle);
  assign Mem_MemRead   = (state_q == StLoad) || (state_q == StRmwRd);
  assign Mem_MemWrite  = (state_q == StStore) || (state_q == StRmwWr);
  assign Mem_Address   = (Mem_MemRead || Mem_MemWrite) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign Mem_WriteData = (state_q == StStore) ? wdata_q :
                         (state_q == StRmwWr) ? merged  : '0;
  assign Rsp_Valid     = (state_q == StResp);
  assign Rsp_Misalign  = Rsp_Valid && err_q;
  assign Rsp_RData     = (Rsp_Valid && !err_q && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic,
// responses checked against a scoreboard of expected data, misalign flag and latency.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Req_Valid, Req_Ready, Req_Write, Req_Signed;
  logic [1:0]  Req_Size;
  logic [31:0] Req_Addr, Req_WData;
  logic        Rsp_Valid, Rsp_Misalign;
  logic [31:0] Rsp_RData;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Mem_MemWrite, Mem_MemRead;

  always #5 Clk = ~Clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req_Valid    (Req_Valid),
    .Req_Ready    (Req_Ready),
    .Req_Write    (Req_Write),
    .Req_Size     (Req_Size),
    .Req_Signed   (Req_Signed),
    .Req_Addr     (Req_Addr),
    .Req_WData    (Req_WData),
    .Rsp_Valid    (Rsp_Valid),
    .Rsp_RData    (Rsp_RData),
    .Rsp_Misalign (Rsp_Misalign),
    .Mem_Address  (Mem_Address),
    .Mem_WriteData(Mem_WriteData),
    .Mem_MemWrite (Mem_MemWrite),
    .Mem_MemRead  (Mem_MemRead),
    .Mem_ReadData (Mem_ReadData)
  );

  // Data memory: combinational read, write on rising edge.
  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];
  int          rd_count = 0, wr_count = 0, cyc = 0;

  assign Mem_ReadData = Mem_MemRead ? mem[Mem_Address[5:2]] : 32'h0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Mem_MemWrite) begin
      mem[Mem_Address[5:2]] <= Mem_WriteData;
      wr_count <= wr_count + 1;
    end
    if (Mem_MemRead) rd_count <= rd_count + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;

  // Response monitor and protocol invariants.
  always @(negedge Clk) begin
    if (Rst_n) begin
      total++;
      if (Mem_MemRead && Mem_MemWrite) begin
        bad++;
        $display("FAIL rd_wr_overlap: read=%b write=%b required not both 1", Mem_MemRead,
                 Mem_MemWrite);
      end
      if (!Rsp_Valid) begin
        total++;
        if (Rsp_RData !== 32'h0 || Rsp_Misalign !== 1'b0) begin
          bad++;
          $display("FAIL idle_rsp_zero: rdata=%h mis=%b required 0/0", Rsp_RData, Rsp_Misalign);
        end
      end else if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got Rsp_Valid=1 required no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        total += 3;
        if (Rsp_RData !== e.rdata) begin
          bad++;
          $display("FAIL rsp_rdata: got %h required %h", Rsp_RData, e.rdata);
        end
        if (Rsp_Misalign !== e.mis) begin
          bad++;
          $display("FAIL rsp_misalign: got %b required %b", Rsp_Misalign, e.mis);
        end
        if (cyc - e.hs !== e.lat) begin
          bad++;
          $display("FAIL rsp_latency: got %0d required %0d", cyc - e.hs, e.lat);
        end
      end
    end
  end

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return ad[0];
    if (sz == 2'b10) return ad[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] ad,
                                             input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * ad[1:0])) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * ad[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] ad,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask, sh;
    if (sz == 2'b00) begin
      mask = 32'hFF << (8 * ad[1:0]);
      sh   = wd << (8 * ad[1:0]);
    end else if (sz == 2'b01) begin
      mask = 32'hFFFF << (16 * ad[1]);
      sh   = wd << (16 * ad[1]);
    end else begin
      mask = 32'hFFFF_FFFF;
      sh   = wd;
    end
    return (w & ~mask) | (sh & mask);
  endfunction

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    Req_Write  = wr;
    Req_Size   = sz;
    Req_Signed = sg;
    Req_Addr   = ad;
    Req_WData  = wd;
    Req_Valid  = 1'b1;
  endtask

  // Presents one request, waits (bounded) for acceptance, then records its expectation.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] er, input logic em, input int el);
    int n;
    @(negedge Clk);
    drive(wr, sz, sg, ad, wd);
    n = 0;
    while (Req_Ready !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (Req_Ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: Req_Ready=%b required 1", Req_Ready);
      Req_Valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: er, mis: em, lat: el, hs: cyc});
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rsp_timeout: pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(negedge Clk);
  endtask

  // Model-driven operation: expectations from ref_mem, ref_mem updated for stores.
  task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] ad, input logic [31:0] wd);
    logic        e;
    logic [31:0] r;
    int          l;
    e = model_err(sz, ad);
    r = 32'h0;
    if (e) l = 1;
    else if (!wr) begin
      l = 2;
      r = model_load(ref_mem[ad[5:2]], ad, sz, sg);
    end else begin
      l = (sz == 2'b10) ? 2 : 3;
      ref_mem[ad[5:2]] = model_merge(ref_mem[ad[5:2]], ad, sz, wd);
    end
    issue(wr, sz, sg, ad, wd, r, e, l);
    wait_done();
  endtask

  task automatic test_reset();
    Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'b00; Req_Signed = 1'b0;
    Req_Addr = 32'h0; Req_WData = 32'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({Req_Ready, Rsp_Valid, Rsp_Misalign, Mem_MemRead, Mem_MemWrite} !== 5'b0 ||
        Rsp_RData !== 32'h0 || Mem_Address !== 32'h0 || Mem_WriteData !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b rd=%b wr=%b addr=%h required all 0",
               Req_Ready, Rsp_Valid, Mem_MemRead, Mem_MemWrite, Mem_Address);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    total++;
    if (Req_Ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b required 1", Req_Ready);
    end
  endtask

  task automatic test_word_load();
    mem[2] = 32'h0000_0369;
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0000_0369, 1'b0, 2);
    wait_done();
  endtask

  task automatic test_byte_load();
    mem[1] = 32'h0000_8050;
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    wait_done();
    issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'h0000_0080, 1'b0, 2);
    wait_done();
    mem[3] = 32'h8001_7F02;
    issue(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    wait_done();
  endtask

  task automatic test_byte_store();
    int r0, w0;
    mem[1] = 32'h1122_3344;
    r0 = rd_count;
    w0 = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AB, 32'h0, 1'b0, 3);
    wait_done();
    total += 2;
    if (rd_count - r0 !== 1 || wr_count - w0 !== 1) begin
      bad++;
      $display("FAIL store_mem_cycles: reads=%0d writes=%0d required 1/1", rd_count - r0,
               wr_count - w0);
    end
    if (mem[1] !== 32'h11AB_3344) begin
      bad++;
      $display("FAIL byte_store_data: got %h required 11ab3344", mem[1]);
    end
  endtask

  task automatic test_misalign();
    int r0, w0;
    mem[0] = 32'hDEAD_BEEF;
    r0 = rd_count;
    w0 = wr_count;
    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_1234, 32'h0, 1'b1, 1);
    wait_done();
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    wait_done();
    total += 2;
    if (rd_count !== r0 || wr_count !== w0) begin
      bad++;
      $display("FAIL misalign_no_mem: reads=%0d writes=%0d required 0/0", rd_count - r0,
               wr_count - w0);
    end
    if (mem[0] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL misalign_mem: got %h required deadbeef", mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic seen_bad;
    mem[1] = 32'h1122_3344;
    w0 = wr_count;
    seen_bad = 1'b0;
    @(negedge Clk);
    drive(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_0055);
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    total++;
    if (Mem_MemRead !== 1'b1) begin
      bad++;
      $display("FAIL rmw_rd_entry: Mem_MemRead=%b required 1", Mem_MemRead);
    end
    Rst_n = 1'b0;
    #1;
    total++;
    if (Mem_MemWrite !== 1'b0 || Rsp_Valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: write=%b valid=%b required 0/0", Mem_MemWrite, Rsp_Valid);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Rsp_Valid !== 1'b0 || Mem_MemWrite !== 1'b0) seen_bad = 1'b1;
    end
    total += 3;
    if (seen_bad || wr_count !== w0) begin
      bad++;
      $display("FAIL reset_mid_activity: writes=%0d stray=%b required 0/0", wr_count - w0,
               seen_bad);
    end
    if (Req_Ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_ready: got %b required 1", Req_Ready);
    end
    if (mem[1] !== 32'h1122_3344) begin
      bad++;
      $display("FAIL reset_mid_mem: got %h required 11223344", mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n, rsp_c, hs2, low;
    mem[2] = 32'h0000_0369;
    mem[1] = 32'h0000_8050;
    rsp_c = -100;
    hs2   = -1;
    low   = 0;
    @(negedge Clk);
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    total++;
    if (Req_Ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_ready: got %b required 1", Req_Ready);
    end
    sb.push_back('{rdata: 32'h0000_0369, mis: 1'b0, lat: 2, hs: cyc});
    @(posedge Clk);
    #1;
    drive(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    n = 0;
    while (n < 20) begin
      @(negedge Clk);
      n++;
      if (Rsp_Valid) rsp_c = cyc;
      if (Req_Ready === 1'b1) begin
        hs2 = cyc;
        break;
      end
      low++;
    end
    total += 2;
    if (low !== 2) begin
      bad++;
      $display("FAIL b2b_busy_ready: low cycles=%0d required 2", low);
    end
    if (hs2 !== rsp_c + 1) begin
      bad++;
      $display("FAIL b2b_accept_cycle: got %0d required %0d", hs2, rsp_c + 1);
    end
    if (hs2 >= 0) sb.push_back('{rdata: 32'h0000_0080, mis: 1'b0, lat: 2, hs: hs2});
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    wait_done();
  endtask

  task automatic test_random();
    int mism;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h9E37_79B9 * (i + 1);
      ref_mem[i] = 32'h9E37_79B9 * (i + 1);
    end
    for (int k = 0; k < 40; k++) begin
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 63)), $urandom);
    end
    mism = 0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        mism++;
        $display("FAIL random_mem[%0d]: got %h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter DATA_W, 32, data word width; only 32 is supported.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Req_Valid  in  1  pipeline presents a load/store request.
REQ-006 Req_Ready  out  1  unit can accept a request (IDLE only).
REQ-007 Req_Write  in  1  1 = store, 0 = load.
REQ-008 Req_Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Req_Signed  in  1  sign-extend load result; ignored for stores.
REQ-010 Req_Addr  in  ADDR_W  byte address.
REQ-011 Req_WData  in  DATA_W  store data, right-aligned.
REQ-012 Rsp_Valid  out  1  one-cycle completion pulse.
REQ-013 Rsp_RData  out  DATA_W  extended load data; 0 for stores and errors.
REQ-014 Rsp_Misalign  out  1  request rejected (misaligned or illegal size), valid with Rsp_Valid.
REQ-015 Mem_Address  out  ADDR_W  word address to data memory, bits [1:0] forced 0.
REQ-016 Mem_WriteData  out  DATA_W  full word to data memory.
REQ-017 Mem_MemWrite  out  1  memory write enable; memory writes on rising Clk.
REQ-018 Mem_MemRead  out  1  memory read enable; memory read is combinational.
REQ-019 Mem_ReadData  in  DATA_W  word from memory; 0 when Mem_MemRead=0.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-021 IDLE: Req_Ready=1; on Req_Valid=1, register Addr/Size/Signed/Write/WData and leave IDLE next edge.
REQ-022 Transition from IDLE: error -> RESP; load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
REQ-023 Error SHALL be Size=11, halfword with Addr[0]=1, or word with Addr[1:0]!=00; no memory enable is asserted.
REQ-024 LOAD: Mem_MemRead=1 for exactly one cycle; Mem_ReadData captured at the closing edge; -> RESP.
REQ-025 STORE: Mem_MemWrite=1 for exactly one cycle with Mem_WriteData=Req_WData; -> RESP.
REQ-026 RMW_RD: Mem_MemRead=1 one cycle, word captured; -> RMW_WR.
REQ-027 RMW_WR: Mem_MemWrite=1 one cycle with the captured word, replacing only the addressed lane(s), little-endian (Addr[1:0]=0 -> bits [7:0]); -> RESP.
REQ-028 RESP: Rsp_Valid=1 for one cycle; -> IDLE. There is no response back-pressure.
REQ-029 Load extraction: byte lane = Addr[1:0], half lane = Addr[1]; zero- or sign-extend to 32 per Req_Signed.
REQ-030 Latency from handshake edge to Rsp_Valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-031 Mem_MemRead and Mem_MemWrite SHALL never be 1 in the same cycle, and both SHALL be 0 outside LOAD/STORE/RMW_*.
REQ-032 Req_Ready=0 in every state but IDLE; requests arriving while busy are not consumed.
REQ-033 Rsp_RData and Rsp_Misalign SHALL be 0 whenever Rsp_Valid=0.

Reset
REQ-034 Rst_n=0 SHALL immediately force IDLE and drive every output 0 except Req_Ready=1 once Rst_n=1.
REQ-035 Reset mid-operation SHALL abort the request: no Mem_MemWrite, no Rsp_Valid, memory untouched if in RMW_RD.

Structure
REQ-036 Package lsu_pkg SHALL hold the state enum, size codes (SZ_BYTE, SZ_HALF, SZ_WORD), and the DATA_W constant.
REQ-037 Lane extract/merge logic SHALL be a combinational sub-module lsu_align, shared by the load and RMW paths.

Verification
REQ-038 Word load, Addr=0x8, mem[2]=0x00000369 -> Rsp_Valid 2 cycles after handshake, Rsp_RData=0x00000369, Rsp_Misalign=0.
REQ-039 Byte load, Addr=0x5, mem[1]=0x00008050, Signed=1 -> 0xFFFFFF80; Signed=0 -> 0x00000080.
REQ-040 Byte store 0xAB, Addr=0x6, mem[1]=0x11223344 -> one read cycle, one write cycle, mem[1]=0x11AB3344, Rsp_Valid 3 cycles after handshake.
REQ-041 Half store, Addr=0x3 -> Rsp_Valid+Rsp_Misalign next cycle, Mem_MemWrite and Mem_MemRead never asserted, memory unchanged.
REQ-042 Rst_n pulsed low during RMW_RD of a byte store -> no Mem_MemWrite, no Rsp_Valid, Req_Ready=1 after release.
REQ-043 Two requests with Req_Valid held high -> Req_Ready=0 while busy; second request accepted the cycle after the first Rsp_Valid.
